mult_tiled_seq: RTL and testbench

//  Iterative signed DWIDTH x DWIDTH multiplier built from one time-shared CHUNK-bit sub-multiplier.
//  Per-transaction mode selects the sub-multiplier: exact, or DR-ALM approximate.

---
 rtl/mult_pkg.sv | 8 +
 rtl/mult_tiled_seq_if.sv | 13 +
 rtl/chunk_mult.sv | 15 +
 rtl/dr_alm_core.sv | 36 +++
 rtl/mult_tiled_seq.sv | 105 ++++++++++
 tb/tb_mult_tiled_seq.sv | 213 +++++++++++++++++++++
 6 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state/mode types and sizing helper for the tiled sequential multiplier
package mult_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} mult_state_e;
  typedef enum logic {MODE_EXACT, MODE_DRALM} mult_mode_e;
  function automatic int chunk_count(input int dw, input int ch);
    return dw / ch;
  endfunction
endpackage

// File: rtl/mult_tiled_seq_if.sv
// mult_tiled_seq_if: operand and result valid/ready channels of the tiled multiplier
interface mult_tiled_seq_if #(parameter int DWIDTH = 16);
  logic i_valid;
  logic o_ready;
  logic [DWIDTH-1:0] i_a;
  logic [DWIDTH-1:0] i_b;
  logic i_mode;
  logic o_valid;
  logic i_ready;
  logic [2*DWIDTH-1:0] o_z;
  modport slave (input i_valid, i_a, i_b, i_mode, i_ready, output o_ready, o_valid, o_z);
  modport master (output i_valid, i_a, i_b, i_mode, i_ready, input o_ready, o_valid, o_z);
endinterface

// File: rtl/chunk_mult.sv
// chunk_mult: CHUNK+1-bit signed sub-multiplier, exact or DR-ALM selected per call
module chunk_mult import mult_pkg::*; #(
  parameter int CHUNK = 8,
  parameter int TRUNC_WIDTH = 6
) (
  input  logic signed [CHUNK:0]     a,
  input  logic signed [CHUNK:0]     b,
  input  mult_mode_e                mode,
  output logic signed [2*CHUNK+1:0] p
);
  logic signed [2*CHUNK+1:0] p_exact, p_alm;
  assign p_exact = a * b;
  dr_alm_core #(.DWIDTH(CHUNK + 1), .TRUNC_WIDTH(TRUNC_WIDTH)) u_alm (.a(a), .b(b), .p(p_alm));
  assign p = (mode == MODE_DRALM) ? p_alm : p_exact;
endmodule

// File: rtl/dr_alm_core.sv
// dr_alm_core: signed dynamic-range approximate logarithmic multiplier (Mitchell log/antilog on truncated mantissas)
module dr_alm_core #(
  parameter int DWIDTH = 16,
  parameter int TRUNC_WIDTH = 6
) (
  input  logic signed [DWIDTH-1:0]   a,
  input  logic signed [DWIDTH-1:0]   b,
  output logic signed [2*DWIDTH-1:0] p
);
  localparam int KW = $clog2(DWIDTH);
  localparam int F = TRUNC_WIDTH;
  logic [DWIDTH-1:0] ma, mb;
  logic [KW-1:0] ka, kb;
  logic [F-1:0] na, nb;
  logic [F:0] s, t;
  logic [KW:0] e;
  logic [2*DWIDTH-1:0] mag;
  // fractions are truncated to F bits with the LSB forced high to centre the truncation error
  always_comb begin
    ma = a[DWIDTH-1] ? -a : a;
    mb = b[DWIDTH-1] ? -b : b;
    ka = '0;
    kb = '0;
    for (int n = 0; n < DWIDTH; n++) begin
      ka = ma[n] ? KW'(n) : ka;
      kb = mb[n] ? KW'(n) : kb;
    end
    na = F'({ma, {F{1'b0}}} >> ka);
    nb = F'({mb, {F{1'b0}}} >> kb);
    s = {1'b0, na | F'(1)} + {1'b0, nb | F'(1)};
    t = s[F] ? s : {1'b1, s[F-1:0]};
    e = {1'b0, ka} + {1'b0, kb} + {{KW{1'b0}}, s[F]};
    mag = (ma == '0 || mb == '0) ? '0 : (2*DWIDTH)'(((2*DWIDTH+F+1)'(t) << e) >> F);
    p = (a[DWIDTH-1] ^ b[DWIDTH-1]) ? -mag : mag;
  end
endmodule

// File: rtl/mult_tiled_seq.sv
// mult_tiled_seq: iterative signed DWIDTH x DWIDTH multiplier, one CHUNK x CHUNK partial product per cycle
module mult_tiled_seq import mult_pkg::*; #(
  parameter int DWIDTH = 16,
  parameter int CHUNK = 8,
  parameter int TRUNC_WIDTH = 6
) (
  input logic        i_clk,
  input logic        i_rst_n,
  mult_tiled_seq_if.slave bus
);
  localparam int K = chunk_count(DWIDTH, CHUNK);
  localparam int IW = K > 1 ? $clog2(K) : 1;
  localparam int PW = 2*CHUNK + 2;
  localparam int ZW = 2*DWIDTH;
  if (DWIDTH % CHUNK != 0) begin : g_chk
    $error("DWIDTH must be a multiple of CHUNK");
  end
  mult_state_e state, state_d;
  mult_mode_e mode, mode_d;
  logic [DWIDTH-1:0] ma, mb, ma_d, mb_d;
  logic sign, sign_d, ready, ready_d, valid, valid_d;
  logic [IW-1:0] i, j, i_d, j_d;
  logic [ZW-1:0] acc, acc_d, acc_sum, z, z_d;
  logic signed [CHUNK:0] ca, cb;
  logic signed [PW-1:0] pp;
  logic last;
  // operands are held as magnitudes so every chunk product is non-negative
  assign ca = {1'b0, CHUNK'(ma >> (CHUNK*int'(i)))};
  assign cb = {1'b0, CHUNK'(mb >> (CHUNK*int'(j)))};
  assign last = (i == IW'(K-1)) && (j == IW'(K-1));
  assign acc_sum = acc + (ZW'(unsigned'(pp)) << (CHUNK*(int'(i) + int'(j))));
  chunk_mult #(.CHUNK(CHUNK), .TRUNC_WIDTH(TRUNC_WIDTH)) u_cm (.a(ca), .b(cb), .mode(mode), .p(pp));
  always_comb begin
    state_d = state;
    mode_d = mode;
    ma_d = ma;
    mb_d = mb;
    sign_d = sign;
    ready_d = ready;
    valid_d = valid;
    i_d = i;
    j_d = j;
    acc_d = acc;
    z_d = z;
    case (state)
      ST_IDLE: if (bus.i_valid && ready) begin
        ma_d = bus.i_a[DWIDTH-1] ? -bus.i_a : bus.i_a;
        mb_d = bus.i_b[DWIDTH-1] ? -bus.i_b : bus.i_b;
        sign_d = bus.i_a[DWIDTH-1] ^ bus.i_b[DWIDTH-1];
        mode_d = mult_mode_e'(bus.i_mode);
        acc_d = '0;
        i_d = '0;
        j_d = '0;
        ready_d = 1'b0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        acc_d = acc_sum;
        j_d = (j == IW'(K-1)) ? '0 : j + IW'(1);
        i_d = (j == IW'(K-1)) ? ((i == IW'(K-1)) ? '0 : i + IW'(1)) : i;
        if (last) begin
          z_d = sign ? -acc_sum : acc_sum;
          valid_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (bus.i_ready) begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      mode <= MODE_EXACT;
      ma <= '0;
      mb <= '0;
      sign <= 1'b0;
      ready <= 1'b1;
      valid <= 1'b0;
      i <= '0;
      j <= '0;
      acc <= '0;
      z <= '0;
    end else begin
      state <= state_d;
      mode <= mode_d;
      ma <= ma_d;
      mb <= mb_d;
      sign <= sign_d;
      ready <= ready_d;
      valid <= valid_d;
      i <= i_d;
      j <= j_d;
      acc <= acc_d;
      z <= z_d;
    end
  end
  assign bus.o_ready = ready;
  assign bus.o_valid = valid;
  assign bus.o_z = z;
endmodule

// File: tb/tb_mult_tiled_seq.sv
// tb_mult_tiled_seq: random and directed transactions checked against a transaction-level reference model
module tb_mult_tiled_seq;
  localparam int K = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mult_tiled_seq_if #(.DWIDTH(16)) bus();
  mult_tiled_seq #(.DWIDTH(16), .CHUNK(8), .TRUNC_WIDTH(6)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  int tests = 0;
  int fails = 0;
  logic m_ready, m_valid;
  logic [31:0] m_z, m_pend;
  int m_cnt;
  int edge_no = 0;
  int acc_edges[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic longint dralm(input longint x, input longint y);
    int kx = 0;
    int ky = 0;
    longint fx, fy, s;
    if (x == 0 || y == 0) return 0;
    while ((longint'(1) << (kx + 1)) <= x) kx++;
    while ((longint'(1) << (ky + 1)) <= y) ky++;
    fx = ((x * 64 / (longint'(1) << kx)) - 64) | 1;
    fy = ((y * 64 / (longint'(1) << ky)) - 64) | 1;
    s = fx + fy;
    if (s < 64) return (64 + s) * (longint'(1) << (kx + ky)) / 64;
    return s * (longint'(1) << (kx + ky + 1)) / 64;
  endfunction
  function automatic logic [31:0] ref_mult(input logic signed [15:0] a, input logic signed [15:0] b, input logic m);
    longint sa = a;
    longint sb = b;
    longint ma = (sa < 0) ? -sa : sa;
    longint mb = (sb < 0) ? -sb : sb;
    longint sum = 0;
    if (!m) return 32'(sa * sb);
    for (int ci = 0; ci < K; ci++)
      for (int cj = 0; cj < K; cj++)
        sum += dralm((ma >> (8*ci)) & 255, (mb >> (8*cj)) & 255) << (8*(ci + cj));
    return ((sa < 0) != (sb < 0)) ? 32'(-sum) : 32'(sum);
  endfunction
  // result appears K*K edges after the accept edge, is held until consumed, then the block idles one edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_z <= '0;
      m_cnt <= 0;
    end else begin
      edge_no <= edge_no + 1;
      if (m_ready && bus.i_valid) begin
        m_ready <= 1'b0;
        m_cnt <= K*K;
        m_pend <= ref_mult(bus.i_a, bus.i_b, bus.i_mode);
        acc_edges.push_back(edge_no);
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_valid <= 1'b1;
          m_z <= m_pend;
        end
      end else if (m_valid && bus.i_ready) begin
        m_valid <= 1'b0;
        m_ready <= 1'b1;
      end
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_ready", bus.o_ready, m_ready);
      chk("cyc_valid", bus.o_valid, m_valid);
      if (m_valid) chk("cyc_z", bus.o_z, m_z);
    end
  end
  task automatic scramble();
    bus.i_a = 16'($urandom);
    bus.i_b = 16'($urandom);
    bus.i_mode = 1'($urandom);
  endtask
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic m, input int hold,
                         output int lat, output logic [31:0] z);
    int n = 0;
    bus.i_a = a;
    bus.i_b = b;
    bus.i_mode = m;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b0;
    while (!bus.o_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", bus.o_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    scramble();
    lat = 1;
    while (!bus.o_valid && lat < 40) begin
      @(negedge clk);
      lat++;
      scramble();
    end
    z = bus.o_z;
    chk("valid_seen", bus.o_valid, 1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_z", bus.o_z, z);
      chk("hold_valid", bus.o_valid, 1);
      chk("hold_ready", bus.o_ready, 0);
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    chk("rel_valid", bus.o_valid, 0);
    chk("rel_ready", bus.o_ready, 1);
  endtask
  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7fff;
      3: return 16'hffff;
      default: return 16'($urandom);
    endcase
  endfunction
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
    $fatal(1);
  end
  initial begin
    int lat;
    logic [31:0] z;
    logic [15:0] ra, rb;
    logic rm;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b0;
    bus.i_a = '0;
    bus.i_b = '0;
    bus.i_mode = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_z", bus.o_z, 0);
    rst_n = 1'b1;
    chk("pin_3x-5", ref_mult(16'sd3, -16'sd5, 1'b0), 32'hFFFFFFF1);
    chk("pin_minxmin", ref_mult(16'h8000, 16'h8000, 1'b0), 32'h40000000);
    chk("pin_minxmax", ref_mult(16'h8000, 16'h7fff, 1'b0), 32'hC0008000);
    chk("pin_alm_1000x-700", ref_mult(16'sd1000, -16'sd700, 1'b1), 32'hFFF58000);
    chk("pin_alm_zero", ref_mult(16'sd0, -16'sd1234, 1'b1), 32'h0);
    run_txn(16'sd3, -16'sd5, 1'b0, 0, lat, z);
    chk("lat_t1", lat, 5);
    chk("z_3x-5", z, 32'hFFFFFFF1);
    run_txn(16'h8000, 16'h8000, 1'b0, 0, lat, z);
    chk("z_minxmin", z, 32'h40000000);
    run_txn(16'h8000, 16'h7fff, 1'b0, 0, lat, z);
    chk("z_minxmax", z, 32'hC0008000);
    run_txn(16'sd0, -16'sd1234, 1'b1, 0, lat, z);
    chk("z_alm_zero", z, 32'h0);
    run_txn(16'sd1000, -16'sd700, 1'b1, 0, lat, z);
    chk("z_alm_1000x-700", z, 32'hFFF58000);
    chk("z_alm_sign", z[31], 1);
    run_txn(16'sd1234, -16'sd77, 1'b1, 3, lat, z);
    chk("z_backpressure", z, ref_mult(16'sd1234, -16'sd77, 1'b1));
    acc_edges.delete();
    bus.i_a = 16'sd321;
    bus.i_b = -16'sd99;
    bus.i_mode = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    repeat (20) @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (8) @(negedge clk);
    bus.i_ready = 1'b0;
    chk("b2b_count_ok", acc_edges.size() >= 3, 1);
    for (int q = 1; q < acc_edges.size(); q++) chk("b2b_ii", acc_edges[q] - acc_edges[q-1], 6);
    bus.i_a = 16'sd500;
    bus.i_b = 16'sd600;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 20 && !bus.o_ready; n++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.i_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", bus.o_valid, 0);
    chk("arst_ready", bus.o_ready, 1);
    chk("arst_z", bus.o_z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(-16'sd12345, 16'sd321, 1'b0, 1, lat, z);
    chk("z_after_rst", z, ref_mult(-16'sd12345, 16'sd321, 1'b0));
    for (int t = 0; t < 60; t++) begin
      ra = pick();
      rb = pick();
      rm = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_txn(ra, rb, rm, $urandom_range(0, 3), lat, z);
      chk("rand_z", z, ref_mult(ra, rb, rm));
      chk("rand_lat", lat, 5);
    end
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
